// File: rtl/incr_seq_ctrl.sv
// incr_seq_ctrl: sequencing register stage around an external 2-bit +1 incrementer.
// Holds the current value, feeds it to the incrementer, and captures the returned
// sum/carry once per cycle for a programmed number of steps. Carry-outs are
// counted in a saturating wrap counter. A one-cycle done pulse marks completion.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last run
// RUN   | one increment per cycle until the remaining count runs out
// DONE  | one-cycle completion pulse; results hold, then back to IDLE
module incr_seq_ctrl #(
   parameter int STEP_W = 4,
   parameter int WRAP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        load_val,
   input  logic [STEP_W-1:0] steps,
   output logic [1:0]        inc_a,
   input  logic [1:0]        inc_sum,
   input  logic              inc_stat,
   output logic [1:0]        count,
   output logic [WRAP_W-1:0] wraps,
   output logic              wrap_sat,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};
   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

   state_t            state_q, state_d;
   logic [1:0]        count_q, count_d;
   logic [WRAP_W-1:0] wraps_q, wraps_d;
   logic              wrap_sat_q, wrap_sat_d;
   logic [STEP_W-1:0] remaining_q, remaining_d;

   // State and result registers; reset aborts any run without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         count_q     <= 2'd0;
         wraps_q     <= '0;
         wrap_sat_q  <= 1'b0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         wraps_q     <= wraps_d;
         wrap_sat_q  <= wrap_sat_d;
         remaining_q <= remaining_d;
      end
   end

   // Next-state and register update logic; everything holds unless a state acts on it.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      wraps_d     = wraps_q;
      wrap_sat_d  = wrap_sat_q;
      remaining_d = remaining_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               count_d     = load_val;
               remaining_d = steps;
               wraps_d     = '0;
               wrap_sat_d  = 1'b0;
               state_d     = (steps != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            count_d     = inc_sum;
            remaining_d = remaining_q - STEP_ONE;
            if (inc_stat) begin
               if (wraps_q == WRAP_MAX) begin
                  wrap_sat_d = 1'b1;
               end else begin
                  wraps_d = wraps_q + 1'b1;
               end
            end
            // Leaving at 1 means remaining never wraps below zero.
            if (remaining_q == STEP_ONE) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign inc_a    = count_q;
   assign count    = count_q;
   assign wraps    = wraps_q;
   assign wrap_sat = wrap_sat_q;
   assign busy     = (state_q == S_RUN) || (state_q == S_DONE);
   assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_incr_seq_ctrl.sv
// Scoreboard bench for incr_seq_ctrl, built with STEP_W=5 and WRAP_W=2 so that
// wrap saturation is reachable with short runs. The incrementer is modelled here.
module tb_incr_seq_ctrl;

   localparam int STEP_W = 5;
   localparam int WRAP_W = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [1:0]        load_val = 2'd0;
   logic [STEP_W-1:0] steps = '0;
   logic [1:0]        inc_a;
   logic [1:0]        inc_sum;
   logic              inc_stat;
   logic [1:0]        count;
   logic [WRAP_W-1:0] wraps;
   logic              wrap_sat;
   logic              busy;
   logic              done;

   incr_seq_ctrl #(.STEP_W(STEP_W), .WRAP_W(WRAP_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .load_val (load_val),
      .steps    (steps),
      .inc_a    (inc_a),
      .inc_sum  (inc_sum),
      .inc_stat (inc_stat),
      .count    (count),
      .wraps    (wraps),
      .wrap_sat (wrap_sat),
      .busy     (busy),
      .done     (done)
   );

   // External 2-bit +1 incrementer.
   assign inc_sum  = inc_a + 2'd1;
   assign inc_stat = (inc_a == 2'd3);

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cnt;
      int wr;
      int sat;
      int start_edge;
      int done_cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   rem = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: a run of N increments from v passes 3->0 exactly (v+N)/4 times.
   function automatic exp_t predict(input int ld, input int n, input int edge_e);
      exp_t e;
      int carries;
      int wmax;
      wmax         = (1 << WRAP_W) - 1;
      carries      = (ld + n) / 4;
      e.cnt        = (ld + n) % 4;
      e.wr         = (carries > wmax) ? wmax : carries;
      e.sat        = (carries > wmax) ? 1 : 0;
      e.start_edge = edge_e;
      e.done_cyc   = edge_e + n;
      return e;
   endfunction

   // One input cycle; the model knows when the DUT can accept a start.
   task automatic drive(input bit st, input int ld, input int n);
      @(negedge clk);
      if (rem > 0) rem--;
      start    = st;
      load_val = 2'(ld);
      steps    = STEP_W'(n);
      if (st && rem == 0 && rst_n) begin
         q.push_back(predict(ld, n, cyc + 1));
         rem = n + 2;
      end
   endtask

   // Monitor: busy window and results at every done pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy", int'(busy), (q.size() > 0 && cyc >= q[0].start_edge) ? 1 : 0);
         if (done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               check("count", int'(count), q[0].cnt);
               check("wraps", int'(wraps), q[0].wr);
               check("wrap_sat", int'(wrap_sat), q[0].sat);
               check("done_latency", cyc, q[0].done_cyc);
               void'(q.pop_front());
            end
         end else if (q.size() > 0 && cyc > q[0].done_cyc + 2) begin
            check("done_timeout", cyc, q[0].done_cyc);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      int guard;
      // Reset state
      #12;
      check("rst_count", int'(count), 0);
      check("rst_wraps", int'(wraps), 0);
      check("rst_sat", int'(wrap_sat), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed runs
      drive(1, 2, 3);
      repeat (6) drive(0, 0, 0);
      drive(1, 1, 0);
      repeat (3) drive(0, 0, 0);
      drive(1, 0, 16);
      repeat (19) drive(0, 0, 0);

      // start pulsed mid-run is ignored
      drive(1, 1, 5);
      drive(0, 0, 0);
      drive(1, 3, 9);
      drive(1, 2, 1);
      repeat (5) drive(0, 0, 0);

      // Asynchronous reset after 4 increments of a 10-step run
      drive(1, 0, 10);
      repeat (4) drive(0, 0, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      q.delete();
      rem = 0;
      #1;
      check("abort_count", int'(count), 0);
      check("abort_wraps", int'(wraps), 0);
      check("abort_sat", int'(wrap_sat), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(1, 3, 1);
      repeat (4) drive(0, 0, 0);

      // start held high: a new run every 4 cycles, wraps cleared each time
      repeat (16) drive(1, 3, 2);
      repeat (4) drive(0, 0, 0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         int n;
         n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
         drive($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)), n);
      end

      guard = 0;
      while (q.size() > 0 && guard < 100) begin
         drive(0, 0, 0);
         guard++;
      end
      if (q.size() > 0) check("drain_timeout", q.size(), 0);
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
